apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 161 ++++++++++++++++
 tb/tb_apb_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns one command at a time into an APB SETUP/ACCESS
// transfer and returns the completer's response on a valid/ready channel.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase
// to TIMEOUT_CYCLES cycles. A transfer that reaches the bound ends with
// rsp_err=1 and rsp_rdata=0. Without the macro, ACCESS waits for pready
// indefinitely.
//
// Handshakes: on both the command and the response channel a transfer
// happens on a rising pclk edge where valid and ready are both high. The
// sender holds its payload stable while valid is high and ready is low.
// cmd_ready is high only while the FSM is idle. rsp_valid stays high, with
// rsp_rdata/rsp_err stable, until rsp_ready is seen.
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB requester side
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    // debug: current FSM state (0 idle, 1 setup, 2 access, 3 resp)
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // A zero bound would make the timeout fire before any ACCESS cycle.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_e              state_q;
    logic                cmd_ready_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // Number of ACCESS cycles already spent waiting on pready.
    logic [CNT_W-1:0]    tmo_cnt_q;
`endif

    // Transfer FSM; every output is a register updated with the state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        // Address/control are latched once and held
                        // until the next accepted command.
                        cmd_ready_q <= 1'b0;
                        paddr_q     <= cmd_addr;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        state_q     <= ST_RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_LAST) begin
                        // Last permitted ACCESS cycle without pready.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed pins on the main scenarios plus a random
// run, all checked against a cycle-offset transaction model.
module tb_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    // ---------------- clock / reset / DUT ----------------
    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [1:0]    dbg_state;

    always #5 pclk = ~pclk;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .dbg_state(dbg_state)
    );

    // ---------------- counters / check helper ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc", nm, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // A transfer accepted in cycle N occupies: setup N+1, access
    // N+2 .. N+1+acc_len, response from N+2+acc_len until the handshake.
    int            cyc = 0;
    int            acc_cyc = 0;
    int            acc_len = 1;
    bit            busy = 0;
    bit            after_rst = 0;
    bit            t_to = 0;
    logic [DW-1:0] t_prdata = '0;
    logic          t_perr = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    logic          m_pwrite = 1'b0;
    logic [DW-1:0] m_pwdata = '0;
    logic [DW:0]   t_rsp = '0;
    logic [DW:0]   exp_q[$];

    bit exp_psel, exp_penable, exp_rsp_valid, exp_cmd_ready, exp_after_rst;
    bit check_en = 0;

    // completer plan used when the next command is accepted
    int            plan_w = 0;
    logic [DW-1:0] plan_rdata = '0;
    logic          plan_err = 1'b0;

    task automatic model_step();
        int kp;
        int k;
        kp = cyc - acc_cyc;
        cyc++;
        if (preset) begin
            busy      = 0;
            m_paddr   = '0;
            m_pwrite  = 1'b0;
            m_pwdata  = '0;
            after_rst = 1;
            exp_q.delete();
        end else begin
            if (busy) begin
                if (kp >= 2 + acc_len && rsp_ready) busy = 0;
            end else if (!after_rst && cmd_valid) begin
                busy     = 1;
                acc_cyc  = cyc - 1;
                m_paddr  = cmd_addr;
                m_pwrite = cmd_write;
                m_pwdata = cmd_wdata;
                t_prdata = plan_rdata;
                t_perr   = plan_err;
`ifdef APB_MASTER_TIMEOUT_EN
                t_to    = (plan_w + 1 > TMO);
                acc_len = t_to ? TMO : plan_w + 1;
`else
                t_to    = 0;
                acc_len = plan_w + 1;
`endif
                t_rsp = t_to ? {1'b1, {DW{1'b0}}} : {plan_err, cmd_write ? {DW{1'b0}} : plan_rdata};
                exp_q.push_back(t_rsp);
            end
            after_rst = 0;
        end
        k = cyc - acc_cyc;
        exp_psel      = busy && k >= 1 && k <= 1 + acc_len;
        exp_penable   = busy && k >= 2 && k <= 1 + acc_len;
        exp_rsp_valid = busy && k >= 2 + acc_len;
        exp_cmd_ready = !busy && !after_rst;
        exp_after_rst = after_rst;
    endtask

    // ---------------- driver ----------------
    // Drive the completer for the current cycle, then advance one edge.
    task automatic tick();
        int k;
        k = cyc - acc_cyc;
        if (busy && k >= 2 && k <= 1 + acc_len) begin
            if (k == 1 + acc_len && !t_to) begin
                pready  = 1'b1;
                prdata  = t_prdata;
                pslverr = t_perr;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
        end else begin
            // outside ACCESS these must be ignored, so make them noisy
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
        end
        @(posedge pclk);
        #1;
        model_step();
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int w, input logic [DW-1:0] rd, input logic er);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = a;
        cmd_wdata  = d;
        plan_w     = w;
        plan_rdata = rd;
        plan_err   = er;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge pclk) begin
        if (check_en) begin
            chk("psel", psel, exp_psel);
            chk("penable", penable, exp_penable);
            chk("rsp_valid", rsp_valid, exp_rsp_valid);
            chk("cmd_ready", cmd_ready, exp_cmd_ready);
            chk("paddr", paddr, m_paddr);
            chk("pwrite", pwrite, m_pwrite);
            chk("pwdata", pwdata, m_pwdata);
            if (exp_rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, t_rsp[DW-1:0]);
                chk("rsp_err", rsp_err, t_rsp[DW]);
            end
            if (exp_after_rst) begin
                chk("rst_rdata", rsp_rdata, 0);
                chk("rst_err", rsp_err, 0);
            end
            if (rsp_valid && rsp_ready && !preset) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious_rsp", 1, 0);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("sb_rdata", rsp_rdata, e[DW-1:0]);
                    chk("sb_err", rsp_err, e[DW]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int addr_bad;
        logic [DW-1:0] held;

        // reset
        preset = 1'b1;
        tick();
        check_en = 1;
        chk("reset_psel", psel, 0);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        tick();
        preset = 1'b0;
        tick();
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);

        // zero-wait write
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_paddr", paddr, 32'h10);
        chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_access_penable", penable, 1);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_back_idle", cmd_ready, 1);

        // read with three wait states
        send(1'b0, 32'h4, 32'h0, 3, 32'h1234_5678, 1'b0);
        cnt = 0;
        addr_bad = 0;
        for (int i = 0; i < 12 && !rsp_valid; i++) begin
            if (penable) cnt++;
            if (psel && paddr != 32'h4) addr_bad++;
            tick();
        end
        chk("rd_penable_cycles", cnt, 4);
        chk("rd_paddr_stable", addr_bad, 0);
        chk("rd_rdata", rsp_rdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // read error, response held with backpressure
        send(1'b0, 32'h8, 32'h0, 0, 32'hA5A5_0001, 1'b1);
        tick();
        tick();
        held = rsp_rdata;
        chk("err_rdata", held, 32'hA5A5_0001);
        for (int i = 0; i < 5; i++) begin
            chk("err_hold_valid", rsp_valid, 1);
            chk("err_hold_err", rsp_err, 1);
            chk("err_hold_rdata", rsp_rdata, held);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("err_back_idle", cmd_ready, 1);

        // reset in the middle of ACCESS
        send(1'b0, 32'hC, 32'h0, 5, 32'h0BAD_F00D, 1'b0);
        tick();
        chk("abort_in_access", penable, 1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("abort_psel", psel, 0);
        chk("abort_penable", penable, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        tick();
        chk("abort_cmd_ready", cmd_ready, 1);

        // completer that never answers
        send(1'b0, 32'h20, 32'h0, 200, 32'hFFFF_FFFF, 1'b0);
        tick();
`ifdef APB_MASTER_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (penable) cnt++;
            tick();
        end
        chk("tmo_access_cycles", cnt, TMO);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        cnt = 0;
        for (int i = 0; i < 110; i++) begin
            if (psel && !rsp_valid) cnt++;
            tick();
        end
        chk("notmo_psel_held", cnt, 110);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        tick();
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_write  = 1'($urandom_range(0, 1));
            cmd_addr   = $urandom;
            cmd_wdata  = $urandom;
            rsp_ready  = 1'($urandom_range(0, 1));
            preset     = ($urandom_range(0, 199) == 0);
            plan_w     = ($urandom_range(0, 15) == 0) ? int'($urandom_range(15, 20))
                                                      : int'($urandom_range(0, 4));
            plan_rdata = $urandom;
            plan_err   = ($urandom_range(0, 3) == 0);
            tick();
        end

        // drain
        cmd_valid = 1'b0;
        preset    = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("drain_idle", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
